mem_blk_lat: RTL
================

Name: mem_blk_lat

Overview:
- Clocked, parametrised main-memory model for the cache hierarchy, replacing the zero-latency combinational memory.
- Byte-addressed array, accessed one cache block at a time through a valid/ready request channel and a valid/ready response channel.
- Programmable read/write latency, per-word write masking and an out-of-range error response.
- Sits between the cache controller's miss/write-back path and the memory array; one transaction in flight.

Parameters:
- DEPTH, 1<<15, array size in bytes; must be a multiple of BLK_WIDTH/BYTE.
- RD_LAT, 4, cycles from read acceptance to rsp_valid; legal range 1..255.
- WR_LAT, 2, cycles from write acceptance to rsp_valid; legal range 1..255.
- INIT, 0, if 1 the array is zero-filled at time 0.
- SEED, 1, if 1 the first NSEED_BLK blocks are pseudo-randomly filled at time 0 from fixed seed 32'hDEADBEEF.
- NSEED_BLK, 512, number of seeded blocks.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1 = block write, 0 = block read.
- req_addr  in  PA_WIDTH  byte address; low log2(BLK_WIDTH/BYTE) bits are ignored (block aligned).
- req_wmask  in  BLK_WIDTH/WRD_WIDTH  per-word write enable; bit k covers word k.
- req_wdata  in  BLK_WIDTH  write block; word k at bits [k*WRD_WIDTH +: WRD_WIDTH], bytes little-endian within a word.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_we  out  1  echo of the accepted req_we.
- rsp_err  out  1  address out of range.
- rsp_rdata  out  BLK_WIDTH  read block, same layout as req_wdata; zero for writes and errors.

Behaviour:
- Reset, asynchronous: state IDLE, latency counter 0, rsp_valid=0, rsp_we=0, rsp_err=0, rsp_rdata=0.
  - req_ready=0 while rst is high.
  - Array contents are never cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the aligned address, we, wmask and wdata. Load the counter with (req_we ? WR_LAT : RD_LAT)-1. Go to WAIT.
  - WAIT: req_ready=0. If counter != 0, decrement. If counter == 0, perform the access at that edge and go to RESP.
    - Read: capture the block from the array into rsp_rdata.
    - Write: update only words with wmask=1; bytes of masked-off words are unchanged.
  - RESP: rsp_valid=1, and response fields are stable. On rsp_ready, go to IDLE; rsp_valid falls the next cycle.
- Latency: request accepted at edge N gives rsp_valid high after edge N+LAT, where LAT = RD_LAT or WR_LAT. With rsp_ready held high, the next request is accepted at edge N+LAT+2 at the earliest.
- Range check: out of range when aligned_addr + BLK_WIDTH/BYTE > DEPTH.
  - rsp_err=1, no array write, rsp_rdata=0, same latency as a normal access.
  - No address wrap-around.
- Write with wmask all-zero: legal no-op; still responds after WR_LAT.
- Read issued after a write response sees the written data (the array is updated before RESP).
- Backpressure: RESP may be held any number of cycles; req_ready stays 0 throughout.
- Reset mid-transaction: the transaction is dropped. A write whose commit edge has not occurred leaves the array unchanged; a committed write stays.
- X on req_* while req_valid=0 is ignored.

Decomposition:
- Package mem_pkg, built on the existing PA_WIDTH, BLK_WIDTH, WRD_WIDTH and BYTE macros:
  - WORDS_PER_BLK, BYTES_PER_BLK, BYTES_PER_WORD, BLK_OFS_BITS
  - mem_state_t enum {IDLE, WAIT, RESP}
  - LAT_W = 8
- One sub-module, mem_lat_ctr: loadable 8-bit down-counter with a zero flag, async reset.
- The array and its time-0 init/seed stay in mem_blk_lat.

Test Plan:
- Bench configuration: BLK_WIDTH=128, WRD_WIDTH=32, DEPTH=4096.
- Write addr 0x040, wmask 4'b1111, wdata 0x44444444_33333333_22222222_11111111, RD_LAT=4, WR_LAT=2, rsp_ready=1 -> rsp_valid 2 cycles after acceptance, rsp_err=0. Read of 0x040 then returns the same block 4 cycles after acceptance.
- Write addr 0x04C, wmask 4'b0101, wdata all 0xAAAAAAAA over the block above -> read of 0x040 returns 0x44444444_AAAAAAAA_22222222_AAAAAAAA (the unaligned address maps to block 0x040).
- Read 0x040 with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable for all 6 cycles, req_ready=0, and a new req_valid is not accepted until one cycle after the handshake.
- Read addr 0x1000 (DEPTH) -> rsp_err=1, rsp_rdata=0. Write addr 0x0FF0 with an in-range block -> rsp_err=0.
- Assert rst one cycle after accepting a write to 0x080 (WR_LAT=2, before commit) -> rsp_valid=0 and req_ready=0 immediately. After release, req_ready=1 and read of 0x080 returns the pre-write contents.
- RD_LAT=1 instance, back-to-back reads of 0x000 and 0x010 with rsp_ready=1 -> rsp_valid one cycle after each acceptance, with acceptances 3 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: block geometry, FSM state type and word-mask helper for the block memory model
`ifndef PA_WIDTH
`define PA_WIDTH 32
`endif
`ifndef BLK_WIDTH
`define BLK_WIDTH 128
`endif
`ifndef WRD_WIDTH
`define WRD_WIDTH 32
`endif
`ifndef BYTE
`define BYTE 8
`endif
package mem_pkg;
  localparam int PA_WIDTH = `PA_WIDTH;
  localparam int BLK_WIDTH = `BLK_WIDTH;
  localparam int WRD_WIDTH = `WRD_WIDTH;
  localparam int BYTE = `BYTE;
  localparam int WORDS_PER_BLK = BLK_WIDTH / WRD_WIDTH;
  localparam int BYTES_PER_BLK = BLK_WIDTH / BYTE;
  localparam int BYTES_PER_WORD = WRD_WIDTH / BYTE;
  localparam int BLK_OFS_BITS = $clog2(BYTES_PER_BLK);
  localparam int LAT_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  function automatic logic [BLK_WIDTH-1:0] word_mask(input logic [WORDS_PER_BLK-1:0] m);
    logic [BLK_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < WORDS_PER_BLK; k++) r[k*WRD_WIDTH +: WRD_WIDTH] = {WRD_WIDTH{m[k]}};
    return r;
  endfunction
endpackage

// File: rtl/mem_lat_ctr.sv
// mem_lat_ctr: loadable down-counter timing the access latency; ports: clk, rst (async), load/load_val, dec, zero flag
module mem_lat_ctr
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [LAT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - LAT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_blk_lat.sv
// mem_blk_lat: block-wide main memory with programmable latency, word write mask and range error
// Ports: clk, rst (async, active-high); request channel req_valid/req_ready/req_we/req_addr/req_wmask/req_wdata;
// response channel rsp_valid/rsp_ready/rsp_we/rsp_err/rsp_rdata. One transaction in flight.
module mem_blk_lat
  import mem_pkg::*;
#(
  parameter int DEPTH = 1 << 15,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 2,
  parameter bit INIT = 1'b0,
  parameter bit SEED = 1'b1,
  parameter int NSEED_BLK = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [PA_WIDTH-1:0]      req_addr,
  input  logic [WORDS_PER_BLK-1:0] req_wmask,
  input  logic [BLK_WIDTH-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_we,
  output logic                     rsp_err,
  output logic [BLK_WIDTH-1:0]     rsp_rdata
);
  localparam int NBLK = DEPTH / BYTES_PER_BLK;
  localparam int IDX_W = NBLK > 1 ? $clog2(NBLK) : 1;
  localparam logic [LAT_W-1:0] RD_LD = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LD = LAT_W'(WR_LAT - 1);
  mem_state_t state, state_nxt;
  logic accept, commit, ctr_load, ctr_dec, ctr_zero, we, err;
  logic [PA_WIDTH-1:0] req_blk;
  logic [IDX_W-1:0] idx;
  logic [WORDS_PER_BLK-1:0] wmask;
  logic [BLK_WIDTH-1:0] wdata;
  logic [BLK_WIDTH-1:0] blks [NBLK];
  // Time-0 contents: optional zero fill, then an xorshift32 stream per seeded block
  function automatic logic [BLK_WIDTH-1:0] init_blk(input int b);
    logic [BLK_WIDTH-1:0] r;
    logic [31:0] s;
    r = INIT ? '0 : 'x;
    s = 32'hDEADBEEF ^ (32'(b) * 32'h9E3779B9);
    if (SEED && b < NSEED_BLK)
      for (int k = 0; k < BLK_WIDTH; k += 32) begin
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        r = (r << 32) | BLK_WIDTH'(s);
      end
    return r;
  endfunction
  // Block number of the request; bits above the index feed the range check
  assign req_blk = req_addr >> BLK_OFS_BITS;
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == RESP;
  mem_lat_ctr u_ctr (
    .clk(clk),
    .rst(rst),
    .load(ctr_load),
    .load_val(req_we ? WR_LD : RD_LD),
    .dec(ctr_dec),
    .zero(ctr_zero)
  );
  always_comb begin
    state_nxt = state;
    ctr_load = 1'b0;
    ctr_dec = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: begin
        ctr_load = accept;
        state_nxt = accept ? WAIT : IDLE;
      end
      WAIT: begin
        commit = ctr_zero;
        ctr_dec = !ctr_zero;
        state_nxt = ctr_zero ? RESP : WAIT;
      end
      RESP: state_nxt = rsp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      we <= 1'b0;
      err <= 1'b0;
      wmask <= '0;
      wdata <= '0;
      rsp_we <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        idx <= req_blk[IDX_W-1:0];
        we <= req_we;
        err <= req_blk >= PA_WIDTH'(NBLK);
        wmask <= req_wmask;
        wdata <= req_wdata;
      end
      if (commit) begin
        rsp_we <= we;
        rsp_err <= err;
        rsp_rdata <= (we || err) ? '0 : blks[idx];
      end
    end
  // Array storage is outside the reset domain so reset never disturbs contents
  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    logic [BLK_WIDTH-1:0] blk = init_blk(b);
    always_ff @(posedge clk)
      if (commit && we && !err && idx == IDX_W'(b)) blk <= (blk & ~word_mask(wmask)) | (wdata & word_mask(wmask));
    assign blks[b] = blk;
  end
endmodule
